// File: rtl/tug_of_war_fsm.sv
// Two-player tug-of-war game controller: idle / countdown / play / win sequencing
// driven by an internal game-tick enable, with registered screen, rope and winner outputs.
module tug_of_war_fsm #(
    parameter int W           = 12,
    parameter int TRACK       = 15,
    parameter int COUNT       = 3,
    parameter int TICK_DIV    = 2**22,
    parameter int DEADBAND    = 64,
    parameter int SCREEN_BASE = 16,
    parameter bit AUTO_START  = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [W-1:0]             p1data,
    input  logic [W-1:0]             p2data,
    output logic [5:0]               screen,
    output logic [$clog2(TRACK)-1:0] pos,
    output logic [1:0]               winner,
    output logic                     playing
);

    localparam int PW = $clog2(TRACK);
    localparam int TW = $clog2(TICK_DIV);
    localparam int CW = $clog2(COUNT + 1);

    localparam logic [PW-1:0]  CENTRE   = PW'((TRACK - 1) / 2);
    localparam logic [PW-1:0]  POS_MAX  = PW'(TRACK - 1);
    localparam logic [CW-1:0]  CNT_INIT = CW'(COUNT);
    localparam logic [TW-1:0]  TICK_END = TW'(TICK_DIV - 1);
    localparam logic [5:0]     SCR_ROPE = 6'(SCREEN_BASE);
    localparam logic [5:0]     SCR_CD   = 6'(SCREEN_BASE + TRACK);
    localparam logic [W+1:0]   DB       = (W+2)'(DEADBAND);

    if (SCREEN_BASE + TRACK + COUNT > 63 || (TRACK % 2) != 1 || TRACK < 3 || TICK_DIV < 2) begin : g_param_check
        $error("tug_of_war_fsm: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, COUNTDOWN, PLAY, WIN} state_t;

    state_t          state, state_n;
    logic [TW-1:0]   tick_cnt, tick_cnt_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [PW-1:0]   pos_n, pos_step;
    logic [1:0]      winner_n;
    logic [5:0]      screen_n;
    logic            playing_n;
    logic            tick;
    logic [W+1:0]    a1, a2;
    logic            p1_leads, p2_leads;

    assign tick     = (tick_cnt == TICK_END);
    assign a1       = {2'b00, p1data};
    assign a2       = {2'b00, p2data};
    assign p1_leads = a1 > (a2 + DB);
    assign p2_leads = a2 > (a1 + DB);

    always_comb begin
        pos_step = pos;
        if (p1_leads)
            pos_step = pos + PW'(1);
        else if (p2_leads)
            pos_step = pos - PW'(1);
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        pos_n     = pos;
        winner_n  = winner;
        screen_n  = screen;
        playing_n = playing;
        case (state)
            IDLE, WIN: begin
                if (state == IDLE) screen_n = '0;
                playing_n = 1'b0;
                if (start) begin
                    state_n  = COUNTDOWN;
                    cnt_n    = CNT_INIT;
                    pos_n    = CENTRE;
                    winner_n = 2'b00;
                    screen_n = SCR_CD + 6'(CNT_INIT);
                end
            end
            COUNTDOWN: begin
                if (tick) begin
                    if (cnt != '0) begin
                        cnt_n    = cnt - CW'(1);
                        screen_n = SCR_CD + 6'(cnt - CW'(1));
                    end else begin
                        state_n   = PLAY;
                        pos_n     = CENTRE;
                        screen_n  = SCR_ROPE + 6'(CENTRE);
                        playing_n = 1'b1;
                    end
                end
            end
            PLAY: begin
                if (tick) begin
                    pos_n    = pos_step;
                    screen_n = SCR_ROPE + 6'(pos_step);
                    // The rope move and the win transition share one edge.
                    if (pos_step == POS_MAX) begin
                        state_n   = WIN;
                        winner_n  = 2'b01;
                        playing_n = 1'b0;
                    end else if (pos_step == '0) begin
                        state_n   = WIN;
                        winner_n  = 2'b10;
                        playing_n = 1'b0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (state_n != state || tick)
            tick_cnt_n = '0;
        else
            tick_cnt_n = tick_cnt + TW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= AUTO_START ? COUNTDOWN : IDLE;
            tick_cnt <= '0;
            cnt      <= CNT_INIT;
            pos      <= CENTRE;
            winner   <= 2'b00;
            playing  <= 1'b0;
            screen   <= AUTO_START ? (SCR_CD + 6'(CNT_INIT)) : 6'd0;
        end else begin
            state    <= state_n;
            tick_cnt <= tick_cnt_n;
            cnt      <= cnt_n;
            pos      <= pos_n;
            winner   <= winner_n;
            playing  <= playing_n;
            screen   <= screen_n;
        end
    end

endmodule
